// File: rtl/picorv32_mem_pkg.sv
// Shared types and helpers for the PicoRV32 native-port to SRAM bridge.
package picorv32_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int WSTRB_W = 4;
    localparam int DATA_W  = 32;

    // Inclusive byte-address window compare.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] limit);
        return (addr >= base) && (addr <= limit);
    endfunction

endpackage

// File: rtl/picorv32_mem_lock.sv
// Sticky write-protect lock and protected-window compare for the memory bridge.
module picorv32_mem_lock
    import picorv32_mem_pkg::*;
#(
    parameter logic [31:0] PROT_BASE  = 32'h0000_0000,
    parameter logic [31:0] PROT_LIMIT = 32'h0000_00FF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lock_set,
    input  logic [31:0] addr,
    input  logic        is_write,
    output logic        lock_q,
    output logic        write_blocked
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q <= 1'b0;
        end else if (lock_set) begin
            lock_q <= 1'b1;
        end
    end

    assign write_blocked = lock_q && is_write && in_window(addr, PROT_BASE, PROT_LIMIT);

endmodule

// File: rtl/picorv32_mem_bridge.sv
// PicoRV32 native memory port to single-port synchronous SRAM, with wait states
// and a sticky write-protect window.
module picorv32_mem_bridge
    import picorv32_mem_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          SRAM_AW     = 10,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] PROT_BASE   = 32'h0000_0000,
    parameter logic [31:0] PROT_LIMIT  = 32'h0000_00FF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mem_valid,
    input  logic                 mem_instr,
    input  logic [ADDR_W-1:0]    mem_addr,
    input  logic [DATA_W-1:0]    mem_wdata,
    input  logic [WSTRB_W-1:0]   mem_wstrb,
    output logic                 mem_ready,
    output logic [DATA_W-1:0]    mem_rdata,
    input  logic                 lock_set,
    output logic                 lock_q,
    output logic                 prot_fault,
    output logic                 sram_en,
    output logic [WSTRB_W-1:0]   sram_we,
    output logic [SRAM_AW-1:0]   sram_addr,
    output logic [DATA_W-1:0]    sram_wdata,
    input  logic [DATA_W-1:0]    sram_rdata
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t               state;
    logic [3:0]           wait_cnt;
    logic [ADDR_W-1:0]    req_addr;
    logic [WSTRB_W-1:0]   req_wstrb;
    logic                 rd_pass;
    logic                 in_range;
    logic                 is_write;
    logic                 write_blocked;
    logic                 issue_ok;
    logic                 unused_ok;

    assign unused_ok = &{1'b0, mem_instr};

    assign in_range = (req_addr[ADDR_W-1:SRAM_AW+2] == '0);
    assign is_write = |req_wstrb;

    // Lock state is sampled live in ISSUE, so a lock_set during WAIT still blocks the write.
    picorv32_mem_lock #(
        .PROT_BASE  (PROT_BASE),
        .PROT_LIMIT (PROT_LIMIT)
    ) u_lock (
        .clk           (clk),
        .reset         (reset),
        .lock_set      (lock_set),
        .addr          (32'(req_addr)),
        .is_write      (is_write),
        .lock_q        (lock_q),
        .write_blocked (write_blocked)
    );

    assign issue_ok  = (state == ISSUE) && in_range && !write_blocked;
    assign sram_en   = issue_ok;
    assign sram_we   = issue_ok ? req_wstrb : '0;
    // SRAM read data arrives in the RESP cycle, so it is steered straight through.
    assign mem_rdata = rd_pass ? sram_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            req_addr   <= '0;
            req_wstrb  <= '0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            mem_ready  <= 1'b0;
            prot_fault <= 1'b0;
            rd_pass    <= 1'b0;
        end else begin
            mem_ready  <= 1'b0;
            prot_fault <= 1'b0;
            rd_pass    <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_valid) begin
                        req_addr   <= mem_addr;
                        req_wstrb  <= mem_wstrb;
                        sram_addr  <= mem_addr[SRAM_AW+1:2];
                        sram_wdata <= mem_wdata;
                        wait_cnt   <= WS;
                        state      <= (WS == 4'd0) ? ISSUE : WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt <= 4'd1) begin
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    state      <= RESP;
                    mem_ready  <= 1'b1;
                    prot_fault <= !in_range || write_blocked;
                    rd_pass    <= issue_ok && !is_write;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_picorv32_mem_bridge.sv
// Randomized self-checking bench for picorv32_mem_bridge against a request-level reference model.
module tb_picorv32_mem_bridge;

    localparam int WS = 1;
    localparam int AW = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        lock_set;
    logic        lock_q;
    logic        prot_fault;
    logic        sram_en;
    logic [3:0]  sram_we;
    logic [AW-1:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    logic [31:0] sram    [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];
    bit          lock_m;
    int          vectors;
    int          miscompares;

    picorv32_mem_bridge #(
        .ADDR_W      (32),
        .SRAM_AW     (AW),
        .WAIT_STATES (WS),
        .PROT_BASE   (32'h0000_0000),
        .PROT_LIMIT  (32'h0000_00FF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_valid  (mem_valid),
        .mem_instr  (mem_instr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .lock_set   (lock_set),
        .lock_q     (lock_q),
        .prot_fault (prot_fault),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural synchronous SRAM: read-first, data valid the cycle after sram_en.
    always @(posedge clk) begin
        if (sram_en) begin
            for (int b = 0; b < 4; b++)
                if (sram_we[b]) sram[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
            sram_rdata <= sram[sram_addr];
        end
    end

    // One core request; lock_c is the cycle (counted from acceptance) in which lock_set pulses, -1 for none.
    task automatic run_req(input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input int lock_c, input string tag);
        logic        in_r, is_w, blk, acc, flt;
        logic [31:0] exp_rd;
        int          word;
        int          issue_c;
        int          ready_c;
        issue_c = WS + 1;
        ready_c = WS + 2;
        word    = int'(addr[AW+1:2]);
        in_r = 1'b0; is_w = 1'b0; blk = 1'b0; acc = 1'b0; flt = 1'b0; exp_rd = '0;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
        mem_instr = 1'($urandom % 2);
        for (int c = 1; c <= ready_c; c++) begin
            @(negedge clk);
            if (lock_c >= 0 && c == lock_c + 1) lock_m = 1'b1;
            vectors++;
            if (lock_q !== lock_m) begin
                miscompares++;
                $display("FAIL %s lock_q cyc%0d got %b want %b", tag, c, lock_q, lock_m);
            end
            if (c == issue_c) begin
                in_r   = (addr[31:AW+2] == '0);
                is_w   = (wstrb != 4'd0);
                blk    = is_w && lock_m && (addr <= 32'hFF);
                acc    = in_r && !blk;
                flt    = !in_r || blk;
                exp_rd = (acc && !is_w) ? ref_mem[word] : 32'd0;
                vectors++;
                if (sram_en !== acc) begin
                    miscompares++;
                    $display("FAIL %s sram_en at issue got %b want %b", tag, sram_en, acc);
                end
                vectors++;
                if (sram_we !== (acc ? wstrb : 4'd0)) begin
                    miscompares++;
                    $display("FAIL %s sram_we got %b want %b", tag, sram_we, acc ? wstrb : 4'd0);
                end
                if (acc) begin
                    vectors++;
                    if (sram_addr !== addr[AW+1:2]) begin
                        miscompares++;
                        $display("FAIL %s sram_addr got %h want %h", tag, sram_addr, addr[AW+1:2]);
                    end
                    if (is_w) begin
                        vectors++;
                        if (sram_wdata !== wdata) begin
                            miscompares++;
                            $display("FAIL %s sram_wdata got %h want %h", tag, sram_wdata, wdata);
                        end
                        for (int b = 0; b < 4; b++)
                            if (wstrb[b]) ref_mem[word][b*8 +: 8] = wdata[b*8 +: 8];
                    end
                end
            end else begin
                vectors++;
                if (sram_en !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s sram_en cyc%0d got %b want 0", tag, c, sram_en);
                end
            end
            if (c == ready_c) begin
                vectors++;
                if (mem_ready !== 1'b1 || mem_rdata !== exp_rd || prot_fault !== flt) begin
                    miscompares++;
                    $display("FAIL %s resp ready/rdata/fault got %b/%h/%b want 1/%h/%b",
                             tag, mem_ready, mem_rdata, prot_fault, exp_rd, flt);
                end
                mem_valid = 1'b0;
            end else begin
                vectors++;
                if (mem_ready !== 1'b0 || prot_fault !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s early ready/fault cyc%0d got %b/%b want 0/0",
                             tag, c, mem_ready, prot_fault);
                end
                // Scramble request inputs: the bridge must use the values latched at acceptance.
                mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom);
            end
            lock_set = (c == lock_c);
        end
        lock_set = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; lock_set = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0;
        mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        lock_m = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({mem_ready, prot_fault, lock_q, sram_en} !== 4'b0 || mem_rdata !== 32'd0 ||
            sram_we !== 4'd0 || sram_addr !== '0 || sram_wdata !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_values rdy=%b flt=%b lock=%b en=%b we=%b addr=%h wd=%h rd=%h want all 0",
                     mem_ready, prot_fault, lock_q, sram_en, sram_we, sram_addr, sram_wdata, mem_rdata);
        end
        reset = 1'b0; lock_set = 1'b0;
    endtask

    task automatic test_read();
        run_req(32'h10, 32'h0, 4'b0000, -1, "read_0x10");
    endtask

    task automatic test_partial_write();
        run_req(32'h20, 32'h1234_5678, 4'b0011, -1, "wr_0x20");
        run_req(32'h20, 32'h0, 4'b0000, -1, "rd_0x20");
    endtask

    task automatic test_random(input int n, input string tag);
        logic [31:0] a;
        logic [3:0]  s;
        for (int i = 0; i < n; i++) begin
            if ($urandom % 8 == 0) a = $urandom | 32'h0000_1000;
            else                   a = 32'($urandom_range(0, 4095));
            s = ($urandom % 2 == 0) ? 4'd0 : 4'($urandom);
            run_req(a, $urandom, s, -1, tag);
        end
    endtask

    task automatic test_lock_block();
        run_req(32'h0, 32'h0, 4'b0000, 1, "lock_pulse_read");
        run_req(32'h40, 32'hCAFE_F00D, 4'b1111, -1, "locked_wr_0x40");
        run_req(32'h40, 32'h0, 4'b0000, -1, "rd_0x40");
    endtask

    task automatic test_locked_outside();
        run_req(32'h200, 32'hA5A5_5A5A, 4'b1111, -1, "locked_wr_0x200");
        run_req(32'h200, 32'h0, 4'b0000, -1, "rd_0x200");
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            vectors++;
            if (lock_q !== 1'b1) begin
                miscompares++;
                $display("FAIL lock_sticky cyc%0d got %b want 1", c, lock_q);
            end
        end
    endtask

    task automatic test_out_of_range();
        run_req(32'h0001_0000, 32'h0, 4'b0000, -1, "oor_read");
        run_req(32'h8000_0004, 32'hFFFF_FFFF, 4'b1111, -1, "oor_write");
    endtask

    task automatic test_reset_abort();
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h300; mem_wdata = 32'h0BAD_0BAD; mem_wstrb = 4'b1111;
        @(negedge clk);
        reset = 1'b1; lock_set = 1'b1; mem_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (sram_en !== 1'b0 || mem_ready !== 1'b0 || lock_q !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_in_reset en/rdy/lock got %b/%b/%b want 0/0/0",
                         sram_en, mem_ready, lock_q);
            end
        end
        reset = 1'b0; lock_set = 1'b0; lock_m = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (sram_en !== 1'b0 || mem_ready !== 1'b0 || lock_q !== 1'b0) begin
                miscompares++;
                $display("FAIL abort_after en/rdy/lock got %b/%b/%b want 0/0/0",
                         sram_en, mem_ready, lock_q);
            end
        end
        run_req(32'h300, 32'h0, 4'b0000, -1, "rd_after_abort");
    endtask

    task automatic test_lock_inflight();
        run_req(32'h80, 32'h1111_2222, 4'b1111, 1, "inflight_lock_wr");
        run_req(32'h80, 32'h0, 4'b0000, -1, "rd_0x80");
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        sram_rdata = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        sram[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
        test_reset();
        test_read();
        test_partial_write();
        test_random(30, "rand_unlocked");
        test_lock_block();
        test_locked_outside();
        test_out_of_range();
        test_random(30, "rand_locked");
        test_reset_abort();
        test_lock_inflight();
        test_random(10, "rand_back_to_back");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
